rx_da_filter_ctrl: RTL and testbench

Receive-path frame filter controller for the 64-bit PLS data stream. Buffers the first two blocks of each frame, presents the destination-address block to the DA checker with a single-cycle frame-start strobe, and samples the checker's verdict. Accepted frames are forwarded downstream with SOF/EOF framing; rejected frames are discarded. Sits between the RS receive output and the MAC receive buffer.

---
 rtl/rx_da_filter_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_rx_da_filter_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_da_filter_ctrl.sv
// Receive DA filter controller: holds the SOF and DA blocks, asks the DA checker for a verdict, forwards or discards the frame.
// Latency: SOF beat at t -> TX SOF block at t+3, DA block at t+4; PASS beats forwarded 1 cycle after acceptance.
// Backpressure: RX_READY drops in DECIDE and SEND_DA only; TX side has no backpressure. Stats counters under `DA_FILTER_STATS_EN.
module rx_da_filter_ctrl #(
  parameter int DW = 64
`ifdef DA_FILTER_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [DW-1:0] RX_DATA,
  input  logic          RX_VALID,
  input  logic          RX_SOF,
  input  logic          RX_EOF,
  output logic          RX_READY,
  input  logic          PROMISC,
  output logic          CHK_FRAME_START,
  output logic [DW-1:0] CHK_DATA,
  input  logic          DA_VALID,
  output logic [DW-1:0] TX_DATA,
  output logic          TX_VALID,
  output logic          TX_SOF,
  output logic          TX_EOF,
  output logic          TX_ABORT,
  output logic          FRAME_DROP
`ifdef DA_FILTER_STATS_EN
  ,
  output logic [CNT_W-1:0] ACCEPT_CNT,
  output logic [CNT_W-1:0] DROP_CNT
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_DA = 3'd1,
    S_DECIDE  = 3'd2,
    S_SEND_DA = 3'd3,
    S_PASS    = 3'd4,
    S_DROP    = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] h0_q, h0_d;
  logic [DW-1:0] h1_q, h1_d;
  logic          h1_eof_q, h1_eof_d;
  logic [DW-1:0] tx_dat_q, tx_dat_d;
  logic          tx_vld_q, tx_vld_d;
  logic          tx_sof_q, tx_sof_d;
  logic          tx_eof_q, tx_eof_d;
  logic          tx_abort_q, tx_abort_d;
  logic          runt_drop_q, runt_drop_d;

  logic rx_ready;
  logic chk_start;
  logic decide_accept;
  logic decide_reject;
  logic beat;
  logic accept;

  assign beat   = RX_VALID & rx_ready;
  assign accept = DA_VALID | PROMISC;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (beat && RX_SOF && !RX_EOF) state_d = S_WAIT_DA;
      S_WAIT_DA: if (beat && !RX_SOF) state_d = S_DECIDE;
      S_DECIDE: begin
        if (accept)        state_d = S_SEND_DA;
        else if (h1_eof_q) state_d = S_IDLE;
        else               state_d = S_DROP;
      end
      S_SEND_DA: state_d = h1_eof_q ? S_IDLE : S_PASS;
      S_PASS, S_DROP: begin
        if (beat) begin
          if (RX_SOF)      state_d = S_WAIT_DA;
          else if (RX_EOF) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs; the verdict is only meaningful while the checker strobe is up
  always_comb begin
    rx_ready      = 1'b0;
    chk_start     = 1'b0;
    decide_accept = 1'b0;
    decide_reject = 1'b0;
    case (state_q)
      S_IDLE, S_WAIT_DA, S_PASS, S_DROP: rx_ready = 1'b1;
      S_DECIDE: begin
        chk_start     = 1'b1;
        decide_accept = accept;
        decide_reject = ~accept;
      end
      default: ;
    endcase
  end

  // Holding registers and registered TX stage
  always_comb begin
    h0_d        = h0_q;
    h1_d        = h1_q;
    h1_eof_d    = h1_eof_q;
    tx_dat_d    = tx_dat_q;
    tx_vld_d    = 1'b0;
    tx_sof_d    = 1'b0;
    tx_eof_d    = 1'b0;
    tx_abort_d  = 1'b0;
    runt_drop_d = 1'b0;

    // Any SOF beat (re)starts header capture, except a single-block runt seen in IDLE
    if (beat && RX_SOF) begin
      if (state_q == S_IDLE && RX_EOF) runt_drop_d = 1'b1;
      else                             h0_d        = RX_DATA;
    end

    if (state_q == S_WAIT_DA && beat && !RX_SOF) begin
      h1_d     = RX_DATA;
      h1_eof_d = RX_EOF;
    end

    if (decide_accept) begin
      tx_dat_d = h0_q;
      tx_vld_d = 1'b1;
      tx_sof_d = 1'b1;
    end

    if (state_q == S_SEND_DA) begin
      tx_dat_d = h1_q;
      tx_vld_d = 1'b1;
      tx_eof_d = h1_eof_q;
    end

    // A new SOF while forwarding truncates the outgoing frame: flag it, forward nothing
    if (state_q == S_PASS && beat) begin
      if (RX_SOF) begin
        tx_abort_d = 1'b1;
      end else begin
        tx_dat_d = RX_DATA;
        tx_vld_d = 1'b1;
        tx_eof_d = RX_EOF;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      h0_q        <= '0;
      h1_q        <= '0;
      h1_eof_q    <= 1'b0;
      tx_dat_q    <= '0;
      tx_vld_q    <= 1'b0;
      tx_sof_q    <= 1'b0;
      tx_eof_q    <= 1'b0;
      tx_abort_q  <= 1'b0;
      runt_drop_q <= 1'b0;
    end else begin
      h0_q        <= h0_d;
      h1_q        <= h1_d;
      h1_eof_q    <= h1_eof_d;
      tx_dat_q    <= tx_dat_d;
      tx_vld_q    <= tx_vld_d;
      tx_sof_q    <= tx_sof_d;
      tx_eof_q    <= tx_eof_d;
      tx_abort_q  <= tx_abort_d;
      runt_drop_q <= runt_drop_d;
    end
  end

  assign RX_READY        = rx_ready;
  assign CHK_FRAME_START = chk_start;
  assign CHK_DATA        = h1_q;
  assign TX_DATA         = tx_dat_q;
  assign TX_VALID        = tx_vld_q;
  assign TX_SOF          = tx_sof_q;
  assign TX_EOF          = tx_eof_q;
  assign TX_ABORT        = tx_abort_q;
  // Runt drops follow the beat by one edge; verdict drops show in the DECIDE cycle itself
  assign FRAME_DROP      = runt_drop_q | decide_reject;

`ifdef DA_FILTER_STATS_EN
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating frame counters; aborts are deliberately not counted
  always_comb begin
    acc_cnt_d  = acc_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (decide_accept && acc_cnt_q != {CNT_W{1'b1}})
      acc_cnt_d = acc_cnt_q + CNT_W'(1);
    if ((decide_reject || runt_drop_d) && drop_cnt_q != {CNT_W{1'b1}})
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  // Counter registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      acc_cnt_q  <= acc_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign ACCEPT_CNT = acc_cnt_q;
  assign DROP_CNT   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_rx_da_filter_ctrl.sv
`timescale 1ns/1ps
module tb_rx_da_filter_ctrl;
  localparam int DW = 64;
  localparam logic [47:0] MATCH_DA = 48'h000000_111111;
  localparam logic [47:0] OTHER_DA = 48'h0000_AABBCCDD;
`ifdef DA_FILTER_STATS_EN
  localparam int CNT_W = 4;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b1;
  logic [DW-1:0] RX_DATA = '0;
  logic          RX_VALID = 1'b0;
  logic          RX_SOF = 1'b0;
  logic          RX_EOF = 1'b0;
  logic          RX_READY;
  logic          PROMISC = 1'b0;
  logic          CHK_FRAME_START;
  logic [DW-1:0] CHK_DATA;
  logic          DA_VALID;
  logic [DW-1:0] TX_DATA;
  logic          TX_VALID, TX_SOF, TX_EOF, TX_ABORT, FRAME_DROP;
`ifdef DA_FILTER_STATS_EN
  logic [CNT_W-1:0] ACCEPT_CNT, DROP_CNT;
`endif

  always #5 CLK = ~CLK;

  // DA checker: accepts exactly one station address
  assign DA_VALID = CHK_FRAME_START && (CHK_DATA[47:0] == MATCH_DA);

  rx_da_filter_ctrl #(
    .DW(DW)
`ifdef DA_FILTER_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_SOF(RX_SOF), .RX_EOF(RX_EOF),
    .RX_READY(RX_READY), .PROMISC(PROMISC),
    .CHK_FRAME_START(CHK_FRAME_START), .CHK_DATA(CHK_DATA), .DA_VALID(DA_VALID),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_SOF(TX_SOF), .TX_EOF(TX_EOF),
    .TX_ABORT(TX_ABORT), .FRAME_DROP(FRAME_DROP)
`ifdef DA_FILTER_STATS_EN
    , .ACCEPT_CNT(ACCEPT_CNT), .DROP_CNT(DROP_CNT)
`endif
  );

  typedef struct {
    int unsigned   cyc;
    logic [DW-1:0] dat;
    bit            sof;
    bit            eof;
  } ev_t;

  ev_t         tx_q[$];
  ev_t         chk_q[$];
  int unsigned drop_q[$];
  int unsigned abort_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int unsigned cyc = 0;

  // Reference model: frame phase of the beat stream, pending stall cycles, frame tallies
  localparam int P_OUT = 0, P_HDR = 1, P_FWD = 2, P_DISC = 3;
  int            phase = P_OUT;
  logic [DW-1:0] sof_blk = '0;
  int            stall = 0;
  int            acc = 0;
  int            drp = 0;
  bit            took;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic fail(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s at cycle %0d: got no completion, expected completion", name, cyc);
  endtask

  function automatic logic [DW-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Apply one accepted beat to the reference model; outputs are scheduled by cycle
  task automatic model_beat();
    logic [DW-1:0] d;
    bit s, e;
    d = RX_DATA; s = RX_SOF; e = RX_EOF;
    if (s) begin
      if (phase == P_FWD) abort_q.push_back(cyc + 1);
      if (phase == P_OUT && e) begin
        drop_q.push_back(cyc + 1);
        drp++;
      end else begin
        sof_blk = d;
        phase = P_HDR;
      end
    end else begin
      case (phase)
        P_HDR: begin
          chk_q.push_back('{cyc + 1, d, 1'b0, 1'b0});
          if (d[47:0] == MATCH_DA || PROMISC) begin
            tx_q.push_back('{cyc + 2, sof_blk, 1'b1, 1'b0});
            tx_q.push_back('{cyc + 3, d, 1'b0, e});
            acc++;
            stall = 2;
            phase = e ? P_OUT : P_FWD;
          end else begin
            drop_q.push_back(cyc + 1);
            drp++;
            stall = 1;
            phase = e ? P_OUT : P_DISC;
          end
        end
        P_FWD: begin
          tx_q.push_back('{cyc + 1, d, 1'b0, e});
          if (e) phase = P_OUT;
        end
        P_DISC: if (e) phase = P_OUT;
        default: ;
      endcase
    end
  endtask

  // One clock: check ready against the model, consume a beat, land at posedge+1
  task automatic tick();
    bit exp_rdy;
    @(negedge CLK);
    exp_rdy = (stall == 0);
    check("rx_ready", RX_READY, exp_rdy);
    took = 0;
    if (!exp_rdy) stall--;
    else if (RX_VALID && RST_N) begin
      model_beat();
      took = 1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic send(logic [DW-1:0] d, bit s, bit e);
    RX_DATA = d; RX_SOF = s; RX_EOF = e; RX_VALID = 1'b1;
    took = 0;
    for (int i = 0; i < 8 && !took; i++) tick();
    if (!took) fail("beat_accept_timeout");
    RX_VALID = 1'b0; RX_SOF = 1'b0; RX_EOF = 1'b0;
  endtask

  task automatic gap(bit en);
    if (en && $urandom_range(0, 2) == 0) tick();
  endtask

  // trunc_at < 0: complete frame; otherwise stop after trunc_at payload beats with no EOF
  task automatic send_frame(logic [47:0] da, int npay, bit prom, int trunc_at, bit gaps);
    while (stall != 0) tick();
    PROMISC = prom;
    gap(gaps); send(rand64(), 1'b1, 1'b0);
    gap(gaps); send({16'($urandom), da}, 1'b0, (npay == 0 && trunc_at < 0));
    for (int i = 0; i < npay; i++) begin
      if (trunc_at >= 0 && i >= trunc_at) return;
      gap(gaps); send(rand64(), 1'b0, (trunc_at < 0 && i == npay - 1));
    end
  endtask

  task automatic drain();
    RX_VALID = 1'b0;
    repeat (6) tick();
  endtask

  task automatic check_counts(string tag);
`ifdef DA_FILTER_STATS_EN
    check({tag, "_accept_cnt"}, ACCEPT_CNT, (acc > 15) ? 15 : acc);
    check({tag, "_drop_cnt"}, DROP_CNT, (drp > 15) ? 15 : drp);
`else
    check({tag, "_rx_ready_idle"}, RX_READY, 1'b1);
`endif
  endtask

  task automatic do_reset();
    RX_VALID = 1'b0;
    RST_N = 1'b0;
    tx_q.delete(); chk_q.delete(); drop_q.delete(); abort_q.delete();
    phase = P_OUT; stall = 0; acc = 0; drp = 0;
    #2;
    check("rst_tx_valid", TX_VALID, 1'b0);
    check("rst_tx_sof", TX_SOF, 1'b0);
    check("rst_tx_eof", TX_EOF, 1'b0);
    check("rst_tx_abort", TX_ABORT, 1'b0);
    check("rst_tx_data", TX_DATA, '0);
    check("rst_frame_drop", FRAME_DROP, 1'b0);
    check("rst_chk_start", CHK_FRAME_START, 1'b0);
    check("rst_chk_data", CHK_DATA, '0);
    check("rst_rx_ready", RX_READY, 1'b1);
    check_counts("rst");
    repeat (2) tick();
    RST_N = 1'b1;
  endtask

  // Scoreboard monitor: every cycle each output stream either matches its scheduled event or stays quiet
  always @(negedge CLK) begin
    ev_t e;
    if (tx_q.size() > 0 && tx_q[0].cyc == cyc) begin
      e = tx_q.pop_front();
      check("tx_valid", TX_VALID, 1'b1);
      check("tx_data", TX_DATA, e.dat);
      check("tx_sof", TX_SOF, e.sof);
      check("tx_eof", TX_EOF, e.eof);
    end else check("tx_valid_quiet", TX_VALID, 1'b0);
    if (chk_q.size() > 0 && chk_q[0].cyc == cyc) begin
      e = chk_q.pop_front();
      check("chk_frame_start", CHK_FRAME_START, 1'b1);
      check("chk_data", CHK_DATA, e.dat);
    end else check("chk_frame_start_quiet", CHK_FRAME_START, 1'b0);
    if (drop_q.size() > 0 && drop_q[0] == cyc) begin
      void'(drop_q.pop_front());
      check("frame_drop", FRAME_DROP, 1'b1);
    end else check("frame_drop_quiet", FRAME_DROP, 1'b0);
    if (abort_q.size() > 0 && abort_q[0] == cyc) begin
      void'(abort_q.pop_front());
      check("tx_abort", TX_ABORT, 1'b1);
    end else check("tx_abort_quiet", TX_ABORT, 1'b0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected end within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    do_reset();

    // Accept, reject, promiscuous
    send_frame(MATCH_DA, 3, 1'b0, -1, 1'b0); drain(); check_counts("accept");
    send_frame(OTHER_DA, 3, 1'b0, -1, 1'b0); drain(); check_counts("reject");
    send_frame(OTHER_DA, 3, 1'b1, -1, 1'b0); drain(); check_counts("promisc");

    // Runt and minimal two-block frame
    send(rand64(), 1'b1, 1'b1); drain(); check_counts("runt");
    send_frame(MATCH_DA, 0, 1'b0, -1, 1'b0); drain(); check_counts("two_block");

    // SOF mid-forward aborts, then the new frame is filtered normally
    send_frame(MATCH_DA, 3, 1'b0, 1, 1'b0);
    send_frame(OTHER_DA, 2, 1'b0, -1, 1'b0); drain(); check_counts("abort");

    // SOF while waiting for the DA block restarts header capture
    send(rand64(), 1'b1, 1'b0);
    send_frame(MATCH_DA, 1, 1'b0, -1, 1'b0); drain(); check_counts("restart");

    // Reset mid-forward: trailing beats must be ignored
    send_frame(MATCH_DA, 3, 1'b0, 1, 1'b0);
    do_reset();
    send(rand64(), 1'b0, 1'b0);
    send(rand64(), 1'b0, 1'b1);
    drain(); check_counts("reset_mid");

    // Randomized traffic including stray beats, runts and truncations
    for (int f = 0; f < 200; f++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) send(rand64(), 1'b1, 1'b1);
      else if (sel == 1) send(rand64(), 1'b0, 1'($urandom_range(0, 1)));
      else begin
        logic [47:0] da;
        int npay, trunc;
        da = ($urandom_range(0, 2) == 0) ? MATCH_DA :
             ($urandom_range(0, 1) == 0) ? OTHER_DA : {16'($urandom), $urandom};
        npay = $urandom_range(0, 4);
        trunc = ($urandom_range(0, 5) == 0) ? $urandom_range(0, npay) : -1;
        send_frame(da, npay, ($urandom_range(0, 3) == 0), trunc, 1'b1);
      end
    end
    drain(); check_counts("random");

`ifdef DA_FILTER_STATS_EN
    // Counter saturation
    do_reset();
    for (int f = 0; f < 17; f++) send_frame(MATCH_DA, $urandom_range(0, 2), 1'b0, -1, 1'b0);
    drain();
    check("sat_accept_cnt", ACCEPT_CNT, 4'hF);
    check("sat_drop_cnt", DROP_CNT, 4'h0);
`endif

    drain();
    if (tx_q.size() + chk_q.size() + drop_q.size() + abort_q.size() != 0) fail("events_left_pending");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
